// File: rtl/ariane_axi_pkg.sv
// Shared AXI adapter request types used by cache and PTW clients.
package ariane_axi_pkg;

  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

endpackage

// File: rtl/axi_adapter_arbiter_pkg.sv
// Types and helpers for the multi-port front end of the AXI adapter.
package axi_adapter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Port index width, never narrower than one bit.
  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/axi_adapter_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module axi_adapter_arbiter_rr_select
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [port_idx_w(NUM_PORTS)-1:0]     ptr,
  output logic [port_idx_w(NUM_PORTS)-1:0]     idx,
  output logic                                 any
);

  localparam int unsigned IDX_W = port_idx_w(NUM_PORTS);

  int unsigned pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      if (!any && req[IDX_W'(pos)]) begin
        any = 1'b1;
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Round-robin front end letting several clients share one AXI adapter,
// one transaction at a time, with the winning request held in registers.
module axi_adapter_arbiter
  import ariane_axi_pkg::*;
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned AXI_ID_WIDTH = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_PORTS-1:0]      req_i,
  input  ad_req_t                   type_i  [NUM_PORTS],
  input  logic [63:0]               addr_i  [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i [NUM_PORTS],
  input  logic [DATA_WIDTH/8-1:0]   be_i    [NUM_PORTS],
  input  logic [1:0]                size_i  [NUM_PORTS],
  output logic [NUM_PORTS-1:0]      gnt_o,
  output logic [NUM_PORTS-1:0]      valid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic                      adp_req_o,
  output ad_req_t                   adp_type_o,
  output logic [63:0]               adp_addr_o,
  output logic                      adp_we_o,
  output logic [DATA_WIDTH-1:0]     adp_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   adp_be_o,
  output logic [1:0]                adp_size_o,
  output logic [AXI_ID_WIDTH-1:0]   adp_id_o,
  input  logic                      adp_gnt_i,
  input  logic                      adp_valid_i,
  input  logic [DATA_WIDTH-1:0]     adp_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]   adp_id_i
);

  localparam int unsigned PORT_IDX_W = port_idx_w(NUM_PORTS);

  arb_state_e            state_q;
  logic [PORT_IDX_W-1:0] rr_q;
  logic [PORT_IDX_W-1:0] sel_q;
  logic [PORT_IDX_W-1:0] win_idx;
  logic [PORT_IDX_W-1:0] rr_next;
  logic                  win_any;
  logic                  accept;
  logic                  done;
  logic                  id_unused;

  axi_adapter_arbiter_rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .req (req_i),
    .ptr (rr_q),
    .idx (win_idx),
    .any (win_any)
  );

  // A completion seen in ISSUE also counts as the accept for that port.
  assign accept  = !rst_i && (state_q == ISSUE) && (adp_gnt_i || adp_valid_i);
  assign done    = !rst_i && adp_valid_i && ((state_q == ISSUE) || (state_q == WAIT_DONE));
  assign rr_next = (sel_q == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + PORT_IDX_W'(1);

  assign adp_req_o = (state_q == ISSUE);
  assign adp_id_o  = AXI_ID_WIDTH'(sel_q);
  assign gnt_o     = accept ? (NUM_PORTS'(1) << sel_q) : '0;
  assign valid_o   = done ? (NUM_PORTS'(1) << sel_q) : '0;
  assign rdata_o   = done ? adp_rdata_i : '0;
  assign id_unused = ^adp_id_i[AXI_ID_WIDTH-1:PORT_IDX_W];

  // Arbitration state, latched request and sticky ID error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      err_o       <= 1'b0;
      adp_type_o  <= SINGLE_REQ;
      adp_addr_o  <= '0;
      adp_we_o    <= 1'b0;
      adp_wdata_o <= '0;
      adp_be_o    <= '0;
      adp_size_o  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            sel_q       <= win_idx;
            adp_type_o  <= type_i[win_idx];
            adp_addr_o  <= addr_i[win_idx];
            adp_we_o    <= we_i[win_idx];
            adp_wdata_o <= wdata_i[win_idx];
            adp_be_o    <= be_i[win_idx];
            adp_size_o  <= size_i[win_idx];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (adp_valid_i)    state_q <= IDLE;
          else if (adp_gnt_i) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (adp_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (done) begin
        rr_q <= rr_next;
        if (adp_id_i[PORT_IDX_W-1:0] != sel_q) err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Scoreboard bench for axi_adapter_arbiter driven by directed adapter handshakes.
module tb_axi_adapter_arbiter;
  import ariane_axi_pkg::*;

  localparam int unsigned NP  = 3;
  localparam int unsigned DW  = 256;
  localparam int unsigned IDW = 10;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NP-1:0]   req_i, we_i, gnt_o, valid_o;
  ad_req_t         type_i  [NP];
  logic [63:0]     addr_i  [NP];
  logic [DW-1:0]   wdata_i [NP];
  logic [DW/8-1:0] be_i    [NP];
  logic [1:0]      size_i  [NP];
  logic [DW-1:0]   rdata_o, adp_wdata_o, adp_rdata_i;
  logic            err_o, adp_req_o, adp_we_o, adp_gnt_i, adp_valid_i;
  ad_req_t         adp_type_o;
  logic [63:0]     adp_addr_o;
  logic [DW/8-1:0] adp_be_o;
  logic [1:0]      adp_size_o;
  logic [IDW-1:0]  adp_id_o, adp_id_i;

  always #5 clk = ~clk;

  axi_adapter_arbiter #(
    .NUM_PORTS    (NP),
    .DATA_WIDTH   (DW),
    .AXI_ID_WIDTH (IDW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .type_i      (type_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .size_i      (size_i),
    .gnt_o       (gnt_o),
    .valid_o     (valid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .adp_req_o   (adp_req_o),
    .adp_type_o  (adp_type_o),
    .adp_addr_o  (adp_addr_o),
    .adp_we_o    (adp_we_o),
    .adp_wdata_o (adp_wdata_o),
    .adp_be_o    (adp_be_o),
    .adp_size_o  (adp_size_o),
    .adp_id_o    (adp_id_o),
    .adp_gnt_i   (adp_gnt_i),
    .adp_valid_i (adp_valid_i),
    .adp_rdata_i (adp_rdata_i),
    .adp_id_i    (adp_id_i)
  );

  typedef struct {
    logic [1:0]    port;
    logic [63:0]   addr;
    logic          we;
    ad_req_t       typ;
    logic [DW-1:0] wdata;
  } iss_t;

  typedef struct {
    logic [1:0]    port;
    logic [DW-1:0] rdata;
  } cmp_t;

  iss_t        iss_q[$];
  cmp_t        cmp_q[$];
  logic [1:0]  gnt_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  iss_t        mon_iss;
  cmp_t        mon_cmp;
  logic [1:0]  mon_gnt;
  logic [NP-1:0] mon_oh;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an accept or completion.
  initial forever begin
    @(negedge clk);
    if (adp_req_o && (adp_gnt_i || adp_valid_i)) begin
      if (iss_q.size() == 0) check("issue_unexpected", DW'(adp_addr_o), '1);
      else begin
        mon_iss = iss_q.pop_front();
        check("adp_addr_o", DW'(adp_addr_o), DW'(mon_iss.addr));
        check("adp_id_o", DW'(adp_id_o), DW'(mon_iss.port));
        check("adp_we_o", DW'(adp_we_o), DW'(mon_iss.we));
        check("adp_type_o", DW'(adp_type_o), DW'(mon_iss.typ));
        check("adp_wdata_o", adp_wdata_o, mon_iss.wdata);
      end
    end
    if (gnt_o != '0) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", DW'(gnt_o), '0);
      else begin
        mon_gnt = gnt_q.pop_front();
        mon_oh  = 3'b001 << mon_gnt;
        check("gnt_o", DW'(gnt_o), DW'(mon_oh));
      end
    end
    if (valid_o != '0) begin
      if (cmp_q.size() == 0) check("valid_unexpected", DW'(valid_o), '0);
      else begin
        mon_cmp = cmp_q.pop_front();
        mon_oh  = 3'b001 << mon_cmp.port;
        check("valid_o", DW'(valid_o), DW'(mon_oh));
        check("rdata_o", rdata_o, mon_cmp.rdata);
      end
    end
  end

  task automatic set_port(input logic [1:0] p, input ad_req_t t, input logic [63:0] a,
                          input logic w, input logic [DW-1:0] d);
    type_i[p]  = t;
    addr_i[p]  = a;
    we_i[p]    = w;
    wdata_i[p] = d;
    be_i[p]    = '1;
    size_i[p]  = 2'd3;
  endtask

  task automatic expect_txn(input logic [1:0] p, input logic [DW-1:0] rd, input bit with_cmp);
    iss_t e;
    cmp_t c;
    e.port = p; e.addr = addr_i[p]; e.we = we_i[p]; e.typ = type_i[p]; e.wdata = wdata_i[p];
    iss_q.push_back(e);
    gnt_q.push_back(p);
    if (with_cmp) begin
      c.port = p; c.rdata = rd;
      cmp_q.push_back(c);
    end
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (!adp_req_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!adp_req_o) check("adp_req_timeout", DW'(adp_req_o), DW'(1));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Adapter model: gnt gd cycles after adp_req_o, valid vd cycles after gnt (0 = same cycle).
  task automatic do_txn(input logic [1:0] port, input int unsigned gd, input int unsigned vd,
                        input logic [DW-1:0] rd, input logic [1:0] rid, input bit sticky,
                        input logic [DW-1:0] hold_wd, input bit scramble);
    wait_req();
    repeat (gd) begin @(posedge clk); #1; end
    adp_gnt_i = 1'b1;
    if (vd == 0) begin
      adp_valid_i = 1'b1; adp_rdata_i = rd; adp_id_i = IDW'(rid);
    end
    @(posedge clk); #1;
    adp_gnt_i = 1'b0; adp_valid_i = 1'b0; adp_rdata_i = '0; adp_id_i = '0;
    if (!sticky) req_i[port] = 1'b0;
    if (scramble) foreach (wdata_i[i]) wdata_i[i] = ~wdata_i[i];
    if (vd > 0) begin
      repeat (vd - 1) begin
        check("adp_wdata_hold", adp_wdata_o, hold_wd);
        @(posedge clk); #1;
      end
      check("adp_wdata_hold", adp_wdata_o, hold_wd);
      adp_valid_i = 1'b1; adp_rdata_i = rd; adp_id_i = IDW'(rid);
      @(posedge clk); #1;
      adp_valid_i = 1'b0; adp_rdata_i = '0; adp_id_i = '0;
    end
  endtask

  logic [DW-1:0] line;

  initial begin
    rst_i = 1'b1; req_i = '0;
    adp_gnt_i = 1'b0; adp_valid_i = 1'b0; adp_rdata_i = '0; adp_id_i = '0;
    foreach (addr_i[i])
      set_port(2'(i), SINGLE_REQ, 64'h1000 + 64'(i) * 64'h100, 1'b0, DW'(64'hA000 + 64'(i)));
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    check("rst_gnt_o", DW'(gnt_o), '0);
    check("rst_valid_o", DW'(valid_o), '0);
    check("rst_adp_req_o", DW'(adp_req_o), '0);
    check("rst_rdata_o", rdata_o, '0);
    check("rst_err_o", DW'(err_o), '0);
    check("rst_adp_addr_o", DW'(adp_addr_o), '0);
    check("rst_adp_wdata_o", adp_wdata_o, '0);

    // Single read on port 1, then ports 0 and 2 together: pointer now at 2.
    set_port(2'd1, SINGLE_REQ, 64'h8000_0010, 1'b0, DW'(64'h0101));
    expect_txn(2'd1, DW'(32'hDEAD_BEEF), 1'b1);
    req_i = 3'b010;
    do_txn(2'd1, 2, 3, DW'(32'hDEAD_BEEF), 2'd1, 1'b0, DW'(64'h0101), 1'b0);
    expect_txn(2'd2, DW'(64'h22), 1'b1);
    expect_txn(2'd0, DW'(64'h33), 1'b1);
    req_i = 3'b101;
    do_txn(2'd2, 0, 1, DW'(64'h22), 2'd2, 1'b0, wdata_i[2], 1'b0);
    do_txn(2'd0, 1, 2, DW'(64'h33), 2'd0, 1'b0, wdata_i[0], 1'b0);

    // All ports request continuously from reset.
    do_reset();
    for (int k = 0; k < 6; k++) expect_txn(2'(k % 3), DW'(64'h200 + 64'(k)), 1'b1);
    req_i = 3'b111;
    for (int k = 0; k < 6; k++)
      do_txn(2'(k % 3), 0, 1, DW'(64'h200 + 64'(k)), 2'(k % 3), 1'b1, wdata_i[k % 3], 1'b0);
    req_i = '0;

    // Cache-line write on port 2 while other inputs change mid-burst.
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    set_port(2'd2, CACHE_LINE_REQ, 64'h8000_1000, 1'b1, line);
    expect_txn(2'd2, '0, 1'b1);
    req_i = 3'b100;
    do_txn(2'd2, 1, 4, '0, 2'd2, 1'b0, line, 1'b1);

    // Wrong response ID on port 1; error stays sticky until reset.
    check("err_before_mismatch", DW'(err_o), '0);
    expect_txn(2'd1, DW'(64'h4444), 1'b1);
    req_i = 3'b010;
    do_txn(2'd1, 0, 2, DW'(64'h4444), 2'd0, 1'b0, wdata_i[1], 1'b0);
    check("err_set", DW'(err_o), DW'(1));
    expect_txn(2'd2, DW'(64'h55), 1'b1);
    req_i = 3'b100;
    do_txn(2'd2, 0, 1, DW'(64'h55), 2'd2, 1'b0, wdata_i[2], 1'b0);
    check("err_sticky_1", DW'(err_o), DW'(1));
    expect_txn(2'd0, DW'(64'h56), 1'b1);
    req_i = 3'b001;
    do_txn(2'd0, 0, 1, DW'(64'h56), 2'd0, 1'b0, wdata_i[0], 1'b0);
    check("err_sticky_2", DW'(err_o), DW'(1));
    do_reset();
    check("err_cleared", DW'(err_o), '0);

    // Reset while waiting for completion abandons the transaction.
    expect_txn(2'd1, DW'(64'h61), 1'b1);
    req_i = 3'b010;
    do_txn(2'd1, 0, 1, DW'(64'h61), 2'd1, 1'b0, wdata_i[1], 1'b0);
    expect_txn(2'd2, '0, 1'b0);
    req_i = 3'b100;
    wait_req();
    adp_gnt_i = 1'b1;
    @(posedge clk); #1;
    adp_gnt_i = 1'b0;
    req_i = '0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_mid_adp_req_o", DW'(adp_req_o), '0);
    repeat (2) @(posedge clk);
    #1;
    expect_txn(2'd1, DW'(64'h62), 1'b1);
    expect_txn(2'd2, DW'(64'h63), 1'b1);
    req_i = 3'b110;
    do_txn(2'd1, 0, 1, DW'(64'h62), 2'd1, 1'b0, wdata_i[1], 1'b0);
    do_txn(2'd2, 1, 1, DW'(64'h63), 2'd2, 1'b0, wdata_i[2], 1'b0);

    // Grant and completion in the same ISSUE cycle.
    expect_txn(2'd0, DW'(64'h6666), 1'b1);
    req_i = 3'b001;
    do_txn(2'd0, 0, 0, DW'(64'h6666), 2'd0, 1'b0, wdata_i[0], 1'b0);
    check("same_cycle_idle_req", DW'(adp_req_o), '0);
    expect_txn(2'd1, DW'(64'h77), 1'b1);
    req_i = 3'b010;
    @(posedge clk); #1;
    check("same_cycle_next_issue", DW'(adp_req_o), DW'(1));
    do_txn(2'd1, 0, 1, DW'(64'h77), 2'd1, 1'b0, wdata_i[1], 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("iss_q_empty", DW'(iss_q.size()), '0);
    check("gnt_q_empty", DW'(gnt_q.size()), '0);
    check("cmp_q_empty", DW'(cmp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
